apb_operand_bridge: RTL and testbench

APB_OPERAND_BRIDGE -- requirements
Module: apb_operand_bridge

---
 rtl/apb_operand_bridge.sv | 141 ++++++++++++++
 tb/tb_apb_operand_bridge.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_operand_bridge.sv
// APB slave bridging a control register and two operand banks for a compute engine.
// Every transfer takes one wait state: IDLE (setup) -> ACCESS -> RESP (pready).
module apb_operand_bridge #(
  parameter  int DATA_WIDTH = 32,
  parameter  int BUS_WIDTH  = 64,
  parameter  int ADDR_WIDTH = 32,
  localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
  localparam int ROW_W      = ($clog2(MAX_DIM) > 1) ? $clog2(MAX_DIM) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [ADDR_WIDTH-1:0] paddr_i,
  input  logic [BUS_WIDTH-1:0]  pwdata_i,
  input  logic [MAX_DIM-1:0]    pstrb_i,
  output logic [BUS_WIDTH-1:0]  prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic                  op_we_a_o,
  output logic                  op_we_b_o,
  output logic [ROW_W-1:0]      op_addr_o,
  output logic [BUS_WIDTH-1:0]  op_data_o,
  output logic [MAX_DIM-1:0]    op_strobe_o,
  input  logic [BUS_WIDTH-1:0]  op_rdata_a_i,
  input  logic [BUS_WIDTH-1:0]  op_rdata_b_i,
  input  logic                  busy_i,
  output logic                  start_o,
  output logic [ROW_W-1:0]      start_row_o
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic [1:0] {
    REG_CTRL = 2'b00,
    REG_A    = 2'b01,
    REG_B    = 2'b10,
    REG_RSVD = 2'b11
  } region_t;

  state_t                 state_q, state_d;
  region_t                region_q;
  logic [ROW_W-1:0]       row_q;
  logic                   write_q;
  logic [BUS_WIDTH-1:0]   wdata_q;
  logic [MAX_DIM-1:0]     strb_q;
  logic [ROW_W-1:0]       start_row_q;
  logic                   start_pend_q;
  logic                   err_q;
  logic [BUS_WIDTH-1:0]   prdata_q;

  logic                   setup;
  logic                   in_access;
  logic                   is_operand;
  logic                   ctrl_write;
  logic                   err_access;
  logic [BUS_WIDTH-1:0]   rd_data;

  // Address bits outside the decoded row/region field are don't-care.
  logic unused_paddr;
  assign unused_paddr = ^{paddr_i[ADDR_WIDTH-1:ROW_W+5], paddr_i[2:0]};

  assign setup      = (state_q == IDLE) && psel_i && !penable_i;
  assign in_access  = (state_q == ACCESS);
  assign is_operand = (region_q == REG_A) || (region_q == REG_B);
  assign ctrl_write = write_q && (region_q == REG_CTRL);

  // Busy is judged live during ACCESS, the cycle in which side effects happen.
  assign err_access = (region_q == REG_RSVD)
                   || (write_q && is_operand && busy_i)
                   || (ctrl_write && wdata_q[0] && busy_i);

  // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    unique case (region_q)
      REG_CTRL: begin
        rd_data[ROW_W:1] = start_row_q;
        rd_data[0]       = busy_i;
      end
      REG_A:    rd_data = op_rdata_a_i;
      REG_B:    rd_data = op_rdata_b_i;
      default:  rd_data = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  // NOTE: datapath registers are reset too, because they drive outputs that must read 0 in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      region_q     <= REG_CTRL;
      row_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= '0;
      start_row_q  <= '0;
      start_pend_q <= 1'b0;
      err_q        <= 1'b0;
      prdata_q     <= '0;
    end else begin
      state_q <= state_d;
      if (setup) begin
        region_q <= region_t'(paddr_i[ROW_W+4:ROW_W+3]);
        row_q    <= paddr_i[3 +: ROW_W];
        write_q  <= pwrite_i;
        wdata_q  <= pwdata_i;
        strb_q   <= pstrb_i;
      end
      if (in_access) begin
        err_q        <= err_access;
        start_pend_q <= ctrl_write && wdata_q[0] && !err_access;
        if (ctrl_write && !err_access) start_row_q <= wdata_q[ROW_W:1];
        if (!write_q) prdata_q <= err_access ? '0 : rd_data;
      end
    end
  end

  assign prdata_o    = prdata_q;
  assign pready_o    = (state_q == RESP);
  assign pslverr_o   = (state_q == RESP) && err_q;
  assign start_o     = (state_q == RESP) && start_pend_q;
  assign start_row_o = start_row_q;

  assign op_we_a_o   = in_access && write_q && (region_q == REG_A) && !err_access;
  assign op_we_b_o   = in_access && write_q && (region_q == REG_B) && !err_access;
  assign op_addr_o   = row_q;
  assign op_data_o   = wdata_q;
  assign op_strobe_o = strb_q;

endmodule

// File: tb/tb_apb_operand_bridge.sv
// Directed self-checking bench for apb_operand_bridge at default widths
// (64-bit bus, two 32-bit elements, one row bit, region at paddr[5:4]).
module tb_apb_operand_bridge;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        psel_i, penable_i, pwrite_i;
  logic [31:0] paddr_i;
  logic [63:0] pwdata_i;
  logic [1:0]  pstrb_i;
  logic [63:0] prdata_o;
  logic        pready_o, pslverr_o;
  logic        op_we_a_o, op_we_b_o;
  logic [0:0]  op_addr_o;
  logic [63:0] op_data_o;
  logic [1:0]  op_strobe_o;
  logic [63:0] op_rdata_a_i, op_rdata_b_i;
  logic        busy_i;
  logic        start_o;
  logic [0:0]  start_row_o;

  int n_checks = 0;
  int n_fail   = 0;

  apb_operand_bridge dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .psel_i       (psel_i),
    .penable_i    (penable_i),
    .pwrite_i     (pwrite_i),
    .paddr_i      (paddr_i),
    .pwdata_i     (pwdata_i),
    .pstrb_i      (pstrb_i),
    .prdata_o     (prdata_o),
    .pready_o     (pready_o),
    .pslverr_o    (pslverr_o),
    .op_we_a_o    (op_we_a_o),
    .op_we_b_o    (op_we_b_o),
    .op_addr_o    (op_addr_o),
    .op_data_o    (op_data_o),
    .op_strobe_o  (op_strobe_o),
    .op_rdata_a_i (op_rdata_a_i),
    .op_rdata_b_i (op_rdata_b_i),
    .busy_i       (busy_i),
    .start_o      (start_o),
    .start_row_o  (start_row_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          n_we_a;
    int          n_we_b;
    int          n_start;
    logic        we_addr;
    logic [63:0] we_data;
    logic [1:0]  we_strb;
    logic        rdy_access;
    logic        err_access;
    logic        rdy_resp;
    logic        err_resp;
    logic        start_resp;
    logic [63:0] prdata;
    logic        start_row;
  } obs_t;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sample(inout obs_t o);
    if (op_we_a_o) begin
      o.n_we_a++;
      o.we_addr = op_addr_o[0];
      o.we_data = op_data_o;
      o.we_strb = op_strobe_o;
    end
    if (op_we_b_o) begin
      o.n_we_b++;
      o.we_addr = op_addr_o[0];
      o.we_data = op_data_o;
      o.we_strb = op_strobe_o;
    end
    if (start_o) o.n_start++;
  endtask

  // Drives SETUP, ACCESS, RESP on consecutive cycles; bus lines are scrambled
  // during ACCESS so only the values latched at SETUP can reach the outputs.
  task automatic apb_xfer(input logic [31:0] addr, input logic we, input logic [63:0] wdata,
                          input logic [1:0] strb, input logic busy, input logic drop_psel,
                          output obs_t o);
    o = '{default: '0};
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = addr; pwrite_i = we;
    pwdata_i = wdata; pstrb_i = strb; busy_i = busy;
    #1 sample(o);
    @(negedge clk_i);
    penable_i = 1'b1; paddr_i = 32'h30; pwdata_i = ~wdata; pstrb_i = ~strb; pwrite_i = ~we;
    if (drop_psel) psel_i = 1'b0;
    #1 sample(o);
    o.rdy_access = pready_o;
    o.err_access = pslverr_o;
    @(negedge clk_i);
    #1 sample(o);
    o.rdy_resp   = pready_o;
    o.err_resp   = pslverr_o;
    o.start_resp = start_o;
    o.prdata     = prdata_o;
    o.start_row  = start_row_o[0];
  endtask

  task automatic bus_idle();
    @(negedge clk_i);
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_prdata"}, prdata_o, 64'h0);
    check({tag, "_pready"}, pready_o, 1'b0);
    check({tag, "_pslverr"}, pslverr_o, 1'b0);
    check({tag, "_we_a"}, op_we_a_o, 1'b0);
    check({tag, "_we_b"}, op_we_b_o, 1'b0);
    check({tag, "_op_addr"}, op_addr_o, 1'b0);
    check({tag, "_op_data"}, op_data_o, 64'h0);
    check({tag, "_op_strobe"}, op_strobe_o, 2'b00);
    check({tag, "_start"}, start_o, 1'b0);
    check({tag, "_start_row"}, start_row_o, 1'b0);
  endtask

  obs_t o, o2;

  initial begin
    rst_ni = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0; busy_i = 1'b0;
    op_rdata_a_i = 64'h0123_4567_89AB_CDEF;
    op_rdata_b_i = 64'hDEAD_BEEF_0000_0001;
    repeat (2) @(negedge clk_i);
    check_all_zero("reset");
    rst_ni = 1'b1;

    // Write bank A row 1
    apb_xfer(32'h18, 1'b1, 64'h1111_2222_3333_4444, 2'b11, 1'b0, 1'b0, o);
    check("wrA_we_a_count", o.n_we_a, 1);
    check("wrA_we_b_count", o.n_we_b, 0);
    check("wrA_addr", o.we_addr, 1'b1);
    check("wrA_data", o.we_data, 64'h1111_2222_3333_4444);
    check("wrA_strb", o.we_strb, 2'b11);
    check("wrA_pready_access", o.rdy_access, 1'b0);
    check("wrA_perr_access", o.err_access, 1'b0);
    check("wrA_pready_resp", o.rdy_resp, 1'b1);
    check("wrA_pslverr", o.err_resp, 1'b0);
    bus_idle();
    #1 check("idle_pready", pready_o, 1'b0);

    // Read bank B row 0
    apb_xfer(32'h20, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0, o);
    check("rdB_prdata", o.prdata, 64'hDEAD_BEEF_0000_0001);
    check("rdB_we_b_count", o.n_we_b, 0);
    check("rdB_pslverr", o.err_resp, 1'b0);

    // Read bank A row 1 (back-to-back with the previous read)
    apb_xfer(32'h18, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0, o);
    check("rdA_prdata", o.prdata, 64'h0123_4567_89AB_CDEF);
    check("rdA_pready", o.rdy_resp, 1'b1);
    bus_idle();

    // CTRL write start=1, row=1
    apb_xfer(32'h00, 1'b1, 64'h3, 2'b11, 1'b0, 1'b0, o);
    check("ctrl_start_count", o.n_start, 1);
    check("ctrl_start_resp", o.start_resp, 1'b1);
    check("ctrl_start_row", o.start_row, 1'b1);
    check("ctrl_wr_pslverr", o.err_resp, 1'b0);
    check("ctrl_wr_prdata_hold", o.prdata, 64'h0123_4567_89AB_CDEF);
    bus_idle();
    #1 check("ctrl_start_after", start_o, 1'b0);

    // CTRL read with busy=1
    apb_xfer(32'h00, 1'b0, 64'h0, 2'b00, 1'b1, 1'b0, o);
    check("ctrl_rd_prdata", o.prdata, 64'h3);

    // Operand write while busy
    apb_xfer(32'h10, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 2'b11, 1'b1, 1'b0, o);
    check("busy_wr_pslverr", o.err_resp, 1'b1);
    check("busy_wr_we_a", o.n_we_a, 0);
    check("busy_wr_prdata_hold", o.prdata, 64'h3);
    check("busy_wr_perr_access", o.err_access, 1'b0);

    // Reserved region read and write
    apb_xfer(32'h30, 1'b0, 64'h0, 2'b00, 1'b0, 1'b0, o);
    check("rsvd_rd_pslverr", o.err_resp, 1'b1);
    check("rsvd_rd_prdata", o.prdata, 64'h0);
    apb_xfer(32'h38, 1'b1, 64'h5555_5555_5555_5555, 2'b11, 1'b0, 1'b0, o);
    check("rsvd_wr_pslverr", o.err_resp, 1'b1);
    check("rsvd_wr_we", o.n_we_a + o.n_we_b, 0);
    bus_idle();
    #1 check("after_err_pslverr", pslverr_o, 1'b0);

    // CTRL start write while busy: error, start_row unchanged
    apb_xfer(32'h00, 1'b1, 64'h1, 2'b11, 1'b1, 1'b0, o);
    check("ctrl_busy_pslverr", o.err_resp, 1'b1);
    check("ctrl_busy_start", o.n_start, 0);
    check("ctrl_busy_row", o.start_row, 1'b1);

    // CTRL write without start while busy is legal: row 0
    apb_xfer(32'h00, 1'b1, 64'h0, 2'b11, 1'b1, 1'b0, o);
    check("ctrl_nostart_pslverr", o.err_resp, 1'b0);
    check("ctrl_nostart_row", o.start_row, 1'b0);
    apb_xfer(32'h00, 1'b1, 64'h2, 2'b11, 1'b0, 1'b0, o);
    check("ctrl_row1_start", o.n_start, 0);
    check("ctrl_row1_row", o.start_row, 1'b1);

    // Back-to-back: A row 0 then B row 1 (psel dropped mid-transfer on the second)
    apb_xfer(32'h10, 1'b1, 64'hCAFE_0000_0000_0001, 2'b01, 1'b0, 1'b0, o);
    apb_xfer(32'h28, 1'b1, 64'h0000_0002_BEEF_0000, 2'b10, 1'b0, 1'b1, o2);
    check("b2b1_we_a", o.n_we_a, 1);
    check("b2b1_we_b", o.n_we_b, 0);
    check("b2b1_addr", o.we_addr, 1'b0);
    check("b2b1_strb", o.we_strb, 2'b01);
    check("b2b2_we_a", o2.n_we_a, 0);
    check("b2b2_we_b", o2.n_we_b, 1);
    check("b2b2_addr", o2.we_addr, 1'b1);
    check("b2b2_data", o2.we_data, 64'h0000_0002_BEEF_0000);
    check("b2b2_pready", o2.rdy_resp, 1'b1);
    bus_idle();

    // Reset in ACCESS of a CTRL start write
    @(negedge clk_i);
    psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h00; pwrite_i = 1'b1;
    pwdata_i = 64'h3; pstrb_i = 2'b11; busy_i = 1'b0;
    @(negedge clk_i);
    penable_i = 1'b1;
    rst_ni = 1'b0;
    #1 check_all_zero("rst_access");
    @(negedge clk_i);
    #1 check("rst_start_next", start_o, 1'b0);
    check("rst_pready_next", pready_o, 1'b0);
    rst_ni = 1'b1;
    psel_i = 1'b0; penable_i = 1'b0;

    apb_xfer(32'h18, 1'b1, 64'h7777_8888_9999_AAAA, 2'b10, 1'b0, 1'b0, o);
    check("post_rst_we_a", o.n_we_a, 1);
    check("post_rst_data", o.we_data, 64'h7777_8888_9999_AAAA);
    check("post_rst_pready", o.rdy_resp, 1'b1);
    check("post_rst_start_row", o.start_row, 1'b0);
    bus_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
